// File: rtl/win3x3_fetch_seq_if.sv
// Handshake and memory-bus bundle between the 3x3 window sequencer and its
// surroundings (dmem read port, downstream filter, big_dmem write port).
interface win3x3_fetch_seq_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] dm_a;
  logic [7:0]  dm_rd;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_data;
  logic [7:0]  win_x;
  logic [7:0]  win_y;
  logic        res_valid;
  logic [23:0] res_data;
  logic        bd_we;
  logic [15:0] bd_a;
  logic [23:0] bd_wd;

  modport master (
    input  start, dm_rd, win_ready, res_valid, res_data,
    output busy, done, dm_a, win_valid, win_data, win_x, win_y, bd_we, bd_a, bd_wd
  );

  modport slave (
    output start, dm_rd, win_ready, res_valid, res_data,
    input  busy, done, dm_a, win_valid, win_data, win_x, win_y, bd_we, bd_a, bd_wd
  );
endinterface

// File: rtl/win3x3_fetch_seq.sv
// 3x3 neighbourhood fetch sequencer for the Canny stages: reads each window from dmem,
// hands it to a filter and writes the 24-bit result to big_dmem. Option: BORDER_REPLICATE_EN.
module win3x3_fetch_seq #(
  parameter int IMG_W    = 200,
  parameter int IMG_H    = 200,
  parameter int BASE_IN  = 0,
  parameter int BASE_OUT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  win3x3_fetch_seq_if.master   bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_PRESENT = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_WRITE   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [7:0]        X_MAX   = 8'(IMG_W - 1);
  localparam logic [7:0]        Y_MAX   = 8'(IMG_H - 1);
  localparam logic signed [9:0] X_MAX_S = $signed(10'(IMG_W - 1));
  localparam logic signed [9:0] Y_MAX_S = $signed(10'(IMG_H - 1));
  localparam logic [15:0]       W16     = 16'(IMG_W);

  logic [2:0]  state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [3:0]  k_q, k_d;
  logic [15:0] bd_a_q, bd_a_d;
  logic [23:0] bd_wd_q, bd_wd_d;
  logic [7:0]  byte_q [9];

  logic [1:0]        kr, kc;
  logic signed [9:0] nx, ny;
  logic              x_lo, x_hi, y_lo, y_hi;
  logic [7:0]        cx, cy;
  logic [15:0]       lin_in, lin_out;
  logic [7:0]        fetch_byte;
  logic [71:0]       win_data_w;

  // Neighbour k sits at row k/3, column k%3 of the window.
  always_comb begin
    kr = 2'd0;
    kc = 2'd0;
    case (k_q)
      4'd0: begin kr = 2'd0; kc = 2'd0; end
      4'd1: begin kr = 2'd0; kc = 2'd1; end
      4'd2: begin kr = 2'd0; kc = 2'd2; end
      4'd3: begin kr = 2'd1; kc = 2'd0; end
      4'd4: begin kr = 2'd1; kc = 2'd1; end
      4'd5: begin kr = 2'd1; kc = 2'd2; end
      4'd6: begin kr = 2'd2; kc = 2'd0; end
      4'd7: begin kr = 2'd2; kc = 2'd1; end
      4'd8: begin kr = 2'd2; kc = 2'd2; end
      default: begin kr = 2'd0; kc = 2'd0; end
    endcase
  end

  assign nx   = $signed({2'b00, x_q}) + $signed({8'b0, kc}) - 10'sd1;
  assign ny   = $signed({2'b00, y_q}) + $signed({8'b0, kr}) - 10'sd1;
  assign x_lo = nx < 10'sd0;
  assign x_hi = nx > X_MAX_S;
  assign y_lo = ny < 10'sd0;
  assign y_hi = ny > Y_MAX_S;
  assign cx   = x_lo ? 8'd0 : (x_hi ? X_MAX : nx[7:0]);
  assign cy   = y_lo ? 8'd0 : (y_hi ? Y_MAX : ny[7:0]);

  assign lin_in  = 16'(BASE_IN) + {8'b0, cy} * W16 + {8'b0, cx};
  assign lin_out = 16'(BASE_OUT) + {8'b0, y_q} * W16 + {8'b0, x_q};

`ifdef BORDER_REPLICATE_EN
  // The clamped address already points at the nearest edge pixel.
  assign fetch_byte = bus.dm_rd;
`else
  logic oob;
  assign oob        = x_lo | x_hi | y_lo | y_hi;
  assign fetch_byte = oob ? 8'h00 : bus.dm_rd;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    bd_a_d  = bd_a_q;
    bd_wd_d = bd_wd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          x_d     = 8'd0;
          y_d     = 8'd0;
          k_d     = 4'd0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (k_q == 4'd8) begin
          k_d     = 4'd0;
          state_d = ST_PRESENT;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_PRESENT: begin
        if (bus.win_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.res_valid) begin
          bd_wd_d = bus.res_data;
          bd_a_d  = lin_out;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Last pixel keeps y in range; the frame ends via DONE anyway.
        if (x_q == X_MAX) begin
          x_d = 8'd0;
          if (y_q == Y_MAX) begin
            state_d = ST_DONE;
          end else begin
            y_d     = y_q + 8'd1;
            state_d = ST_FETCH;
          end
        end else begin
          x_d     = x_q + 8'd1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      k_q     <= 4'd0;
      bd_a_q  <= 16'd0;
      bd_wd_q <= 24'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      bd_a_q  <= bd_a_d;
      bd_wd_q <= bd_wd_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_byte
      always_ff @(posedge clk) begin
        if (reset) begin
          byte_q[gi] <= 8'h00;
        end else if (state_q == ST_FETCH && k_q == 4'(gi)) begin
          byte_q[gi] <= fetch_byte;
        end
      end
    end
  endgenerate

  always_comb begin
    win_data_w = '0;
    for (int i = 0; i < 9; i++) win_data_w[8*i +: 8] = byte_q[i];
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.win_valid = (state_q == ST_PRESENT);
  assign bus.bd_we     = (state_q == ST_WRITE);
  assign bus.dm_a      = (state_q == ST_FETCH) ? lin_in : 16'd0;
  assign bus.win_data  = win_data_w;
  assign bus.win_x     = x_q;
  assign bus.win_y     = y_q;
  assign bus.bd_a      = bd_a_q;
  assign bus.bd_wd     = bd_wd_q;

endmodule

// File: tb/tb_win3x3_fetch_seq.sv
// Directed bench for win3x3_fetch_seq on a 4x3 image with dmem[i] = i+1.
module tb_win3x3_fetch_seq;
  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  win3x3_fetch_seq_if bus();

  win3x3_fetch_seq #(.IMG_W(W), .IMG_H(H), .BASE_IN(0), .BASE_OUT(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.dm_rd = (bus.dm_a < 16'd12) ? 8'(bus.dm_a + 16'd1) : 8'hEE;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      bus.busy,      0);
    chk({tag, "_done"},      bus.done,      0);
    chk({tag, "_win_valid"}, bus.win_valid, 0);
    chk({tag, "_bd_we"},     bus.bd_we,     0);
    chk({tag, "_dm_a"},      bus.dm_a,      0);
    chk({tag, "_win_data"},  bus.win_data,  0);
    chk({tag, "_win_x"},     bus.win_x,     0);
    chk({tag, "_win_y"},     bus.win_y,     0);
    chk({tag, "_bd_a"},      bus.bd_a,      0);
    chk({tag, "_bd_wd"},     bus.bd_wd,     0);
  endtask

`ifdef BORDER_REPLICATE_EN
  localparam logic [71:0] EXP_W00 = 72'h06_05_05_02_01_01_02_01_01;
  localparam logic [71:0] EXP_W32 = 72'h0C_0C_0B_0C_0C_0B_08_08_07;
`else
  localparam logic [71:0] EXP_W00 = 72'h06_05_00_02_01_00_00_00_00;
  localparam logic [71:0] EXP_W32 = 72'h00_00_00_00_0C_0B_00_08_07;
`endif
  localparam logic [71:0] EXP_W11 = 72'h0B_0A_09_07_06_05_03_02_01;

  initial begin
    int exp_a [9] = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
    int c, first_valid, nwin, nwe, nbusy, ndone, done_cycle, wr_seen;
    logic [71:0] w00, w11, w32, held;
    bit done_seen, seen;

    bus.start = 0; bus.win_ready = 0; bus.res_valid = 0; bus.res_data = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // Frame 1: free-running handshakes, start accepted in cycle 0.
    reset = 0;
    bus.win_ready = 1; bus.res_valid = 1; bus.res_data = 24'h123456;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    c = 1; first_valid = -1; nwin = 0; nwe = 0; nbusy = 0; ndone = 0; done_cycle = -1;
    done_seen = 0; w00 = '0; w11 = '0; w32 = '0;
    while (c <= 220 && !done_seen) begin
      if (c >= 1 && c <= 9) chk($sformatf("p00_dm_a_k%0d", c - 1), bus.dm_a, exp_a[c-1]);
      if (bus.win_valid && first_valid < 0) first_valid = c;
      if (bus.win_valid && bus.win_ready) begin
        nwin++;
        if (bus.win_x == 0 && bus.win_y == 0) w00 = bus.win_data;
        if (bus.win_x == 1 && bus.win_y == 1) w11 = bus.win_data;
        if (bus.win_x == 3 && bus.win_y == 2) w32 = bus.win_data;
      end
      if (bus.bd_we) begin
        chk($sformatf("f1_bd_a_%0d", nwe), bus.bd_a, nwe);
        if (nwe == 0) chk("f1_bd_wd", bus.bd_wd, 24'h123456);
        nwe++;
      end
      if (bus.busy) nbusy++;
      if (bus.done) begin ndone++; done_cycle = c; done_seen = 1; end
      @(negedge clk);
      c++;
    end
    chk("f1_completed", done_seen, 1);
    chk("f1_first_valid_cycle", first_valid, 10);
    chk("f1_windows", nwin, 12);
    chk("f1_writes", nwe, 12);
    chk("f1_done_cycle", done_cycle, 145);
    chk("f1_done_pulses", ndone, 1);
    chk("f1_busy_cycles", nbusy, 145);
    chk("f1_done_after", bus.done, 0);
    chk("f1_busy_after", bus.busy, 0);
    chk("win_1_1", w11, EXP_W11);
    chk("win_0_0", w00, EXP_W00);
    chk("win_3_2", w32, EXP_W32);

    // Frame 2: consumer stalls 5 cycles, result arrives 3 cycles late.
    bus.win_ready = 0; bus.res_valid = 0; bus.res_data = '0;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.win_valid) seen = 1;
      else @(negedge clk);
    end
    chk("stall_valid_reached", seen, 1);
    held = bus.win_data;
    chk("stall_win_0_0", held, EXP_W00);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_valid_%0d", i), bus.win_valid, 1);
      chk($sformatf("stall_data_%0d", i), bus.win_data, held);
      chk($sformatf("stall_dm_a_%0d", i), bus.dm_a, 0);
      bus.start = (i == 1);
      @(negedge clk);
    end
    bus.start = 0;
    bus.win_ready = 1;
    @(negedge clk);
    chk("xfer_valid_drop", bus.win_valid, 0);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("wait_no_we_%0d", j), bus.bd_we, 0);
      @(negedge clk);
    end
    bus.res_valid = 1; bus.res_data = 24'hABCDEF;
    @(negedge clk);
    bus.res_valid = 0; bus.res_data = '0;
    chk("late_bd_we", bus.bd_we, 1);
    chk("late_bd_wd", bus.bd_wd, 24'hABCDEF);
    chk("late_bd_a", bus.bd_a, 0);
    @(negedge clk);
    chk("late_bd_we_drop", bus.bd_we, 0);

    // Run pixels 1..4, then reset in the middle of pixel 5's fetch.
    bus.res_valid = 1; bus.res_data = 24'h000777;
    wr_seen = 1;
    for (int i = 0; i < 200 && wr_seen < 5; i++) begin
      if (bus.bd_we) begin
        chk($sformatf("f2_bd_a_%0d", wr_seen), bus.bd_a, wr_seen);
        wr_seen++;
      end
      if (wr_seen < 5) @(negedge clk);
    end
    chk("f2_writes_before_reset", wr_seen, 5);
    repeat (2) @(negedge clk);
    chk("p5_fetching_x", bus.win_x, 1);
    chk("p5_fetching_y", bus.win_y, 1);
    reset = 1;
    @(negedge clk);
    chk_all_zero("midreset");
    reset = 0;
    nwe = 0; nbusy = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.bd_we) nwe++;
      if (bus.busy) nbusy++;
    end
    chk("post_reset_writes", nwe, 0);
    chk("post_reset_busy", nbusy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
